// File: rtl/three_state_arithmetic.sv
// Registered tri-state output stage for a WIDTH-bit ULA result ({borrow, byte}).
// Optional zero/borrow status ports are compiled in with THREE_STATE_FLAGS_EN.
module three_state_arithmetic #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] w,
  input  logic             EN,
  output wire  [WIDTH-1:0] s,
  output logic             drv
`ifdef THREE_STATE_FLAGS_EN
  ,
  output logic             zero,
  output logic             borrow
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             en_q, en_d;

  always_comb begin
    en_d   = EN;
    data_d = data_q;
    if (EN) data_d = w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      en_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  // Bus path stays a bare mux so the release is visible the same cycle en_q drops.
  assign s   = en_q ? data_q : {WIDTH{1'bz}};
  assign drv = en_q;

`ifdef THREE_STATE_FLAGS_EN
  assign zero   = en_q & (data_q[WIDTH-2:0] == '0);
  assign borrow = en_q & data_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_three_state_arithmetic.sv
// Bench for three_state_arithmetic: directed vector table plus randomized traffic
// against a transaction-level model. A second bus driver stands in for another ULA unit.
module tb_three_state_arithmetic;

  localparam int WIDTH = 9;
  localparam logic [WIDTH-1:0] OTHER = 9'h1AA;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] w   = '0;
  tri   [WIDTH-1:0] s_bus;
  logic             drv;
  logic             zero_o, borrow_o;
  logic             oth_en = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what the block last accepted and whether it owns the bus.
  logic             m_own  = 1'b0;
  logic [WIDTH-1:0] m_val  = '0;

  always #5 clk = ~clk;

  // Another unit drives the bus whenever the model says this block is released.
  assign s_bus = oth_en ? OTHER : {WIDTH{1'bz}};

  three_state_arithmetic #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .EN  (en),
    .s   (s_bus),
    .drv (drv)
`ifdef THREE_STATE_FLAGS_EN
    ,
    .zero   (zero_o),
    .borrow (borrow_o)
`endif
  );

`ifndef THREE_STATE_FLAGS_EN
  // Flags port absent: expect them as the spec's definition of the released/driven value.
  always_comb begin
    zero_o   = m_own && (m_val[WIDTH-2:0] == 0);
    borrow_o = m_own && m_val[WIDTH-1];
  end
`endif

  typedef struct {
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] w;
    logic             x_drv;
    logic [WIDTH-1:0] x_s;
    logic             x_zero;
    logic             x_borrow;
  } vec_t;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, advance model, then compare.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r; en = e; w = d;
    @(posedge clk);
    if (r) begin
      m_own = 1'b0;
      m_val = '0;
    end else begin
      m_own = e;
      if (e) m_val = d;
    end
    oth_en = !m_own;
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [WIDTH-1:0] xs;
    xs = m_own ? m_val : OTHER;
    chk({tag, ".s"},   s_bus, xs);
    chk({tag, ".drv"}, {8'b0, drv}, {8'b0, m_own});
`ifdef THREE_STATE_FLAGS_EN
    chk({tag, ".zero"},   {8'b0, zero_o},   {8'b0, m_own && (m_val % 256 == 0)});
    chk({tag, ".borrow"}, {8'b0, borrow_o}, {8'b0, m_own && (m_val >= 256)});
`endif
  endtask

  vec_t vt[$];

  initial begin
    // Directed table: expected values written from the spec, independent of the model.
    vt.push_back('{1, 1, 9'h1A5, 0, OTHER,  0, 0});
    vt.push_back('{1, 1, 9'h1A5, 0, OTHER,  0, 0});
    vt.push_back('{0, 1, 9'h005, 1, 9'h005, 0, 0});
    vt.push_back('{0, 1, 9'h100, 1, 9'h100, 1, 1});
    vt.push_back('{0, 1, 9'h0FF, 1, 9'h0FF, 0, 0});
    vt.push_back('{0, 0, 9'h0FF, 0, OTHER,  0, 0});
    vt.push_back('{0, 1, 9'h03C, 1, 9'h03C, 0, 0});
    vt.push_back('{1, 1, 9'h03C, 0, OTHER,  0, 0});
    vt.push_back('{0, 1, 9'h001, 1, 9'h001, 0, 0});
    for (int i = 0; i <= 8; i++)
      vt.push_back('{0, 1, WIDTH'(i), 1, WIDTH'(i), (i == 0), 0});
    // Toggle 1,0,1 with a new value on each drive cycle.
    vt.push_back('{0, 1, 9'h1F0, 1, 9'h1F0, 0, 1});
    vt.push_back('{0, 0, 9'h055, 0, OTHER,  0, 0});
    vt.push_back('{0, 1, 9'h0AA, 1, 9'h0AA, 0, 0});
    vt.push_back('{0, 0, 9'h000, 0, OTHER,  0, 0});

    // Before the first edge the bus owner is undefined; start in reset.
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].en, vt[i].w);
      chk($sformatf("vec%0d.s", i),   s_bus, vt[i].x_s);
      chk($sformatf("vec%0d.drv", i), {8'b0, drv}, {8'b0, vt[i].x_drv});
`ifdef THREE_STATE_FLAGS_EN
      chk($sformatf("vec%0d.zero", i),   {8'b0, zero_o},   {8'b0, vt[i].x_zero});
      chk($sformatf("vec%0d.borrow", i), {8'b0, borrow_o}, {8'b0, vt[i].x_borrow});
`endif
    end

    // Hand sequence: released hold must not leak stale data, and reset wins over EN.
    step(0, 1, 9'h1C3); chk_model("hold.drive");
    step(0, 0, 9'h000); chk_model("hold.rel");
    step(0, 0, 9'h011); chk_model("hold.rel2");
    step(1, 1, 9'h0EE); chk_model("rst_en.edge");
    step(0, 1, 9'h100); chk_model("rst_en.first");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/three_state_arithmetic.md
# three_state_arithmetic

Registered tri-state output stage for the 9-bit ULA arithmetic result, for example the subtractor's {borrow, difference}. It samples the arithmetic result when enabled and drives it onto the shared 9-bit result bus one clock later. When not enabled, it releases the bus to high impedance so other ULA units can drive it. An optional flag port reports zero/borrow status of the driven value.

## Interface
- WIDTH, 9, result width in bits; bit WIDTH-1 is the borrow/carry bit, bits WIDTH-2:0 are the data byte.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- w  input  WIDTH  arithmetic result from the upstream unit.
- EN  input  1  drive request; active-high.
- s  output (tri)  WIDTH  shared result bus; driven or 'z.
- drv  output  1  high while s is actively driven.
- zero  output  1  (only with THREE_STATE_FLAGS_EN) driven byte s[WIDTH-2:0] equals 0.
- borrow  output  1  (only with THREE_STATE_FLAGS_EN) driven bit s[WIDTH-1].

## Operation
- Internal state:
  - data_q[WIDTH-1:0] holds the sampled result.
  - en_q holds the registered enable.
- Rising edge with rst=1:
  - data_q<=0, en_q<=0.
  - rst has priority over EN.
- Rising edge with rst=0:
  - en_q<=EN.
  - If EN=1, data_q<=w. If EN=0, data_q holds its value.
- Output s:
  - s = en_q ? data_q : {WIDTH{1'bz}}.
  - Continuous assign, no further logic on the bus path.
- drv = en_q.
- Flags (when compiled in):
  - zero = en_q & (data_q[WIDTH-2:0]==0).
  - borrow = en_q & data_q[WIDTH-1].
  - Both are 0 while the bus is released.
- Data is passed through unmodified:
  - No arithmetic, no sign extension, no truncation.
  - All WIDTH bits are sampled and driven bit-exact.
- X/Z on w while EN=1 is captured as-is; no sanitisation.

## Timing
- Latency:
  - EN=1 sampled at edge N → s shows w(N) and drv=1 after edge N.
  - s updates at every edge while EN stays 1; throughput 1 value/cycle.
- Release:
  - EN=0 sampled at edge N → s='z and drv=0 after edge N.
  - No extra turnaround cycle.
- During reset and after reset: s='z, drv=0, zero=0, borrow=0, data_q=0.
- Reset mid-drive:
  - The bus is released at the reset edge, even if EN=1.
  - The first drive occurs after the first non-reset edge with EN=1.
- Back-to-back EN toggling (1,0,1): s alternates value / 'z / new value per cycle. The held data_q is irrelevant while released.
- Bus contention between units is the system's responsibility. This block never drives while en_q=0.

## Configuration
- THREE_STATE_FLAGS_EN:
  - Defined: the zero and borrow ports and their logic exist, per Operation.
  - Undefined: the ports are absent. s and drv behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with EN=1, w=9'h1A5 → s=9'bz, drv=0 throughout. Flags=0.
- Drive: rst=0, EN=1, w=9'h005 at edge N → after N: s=9'h005, drv=1, zero=0, borrow=0.
- Borrow/zero: EN=1, w=9'h100 → s=9'h100, zero=1, borrow=1. Then w=9'h0FF → s=9'h0FF, zero=0, borrow=0.
- Release: EN=0 after driving 9'h0FF → next edge s=9'bz, drv=0, flags=0. Re-assert EN with w=9'h03C → s=9'h03C one edge later.
- Reset mid-drive: EN=1 with s=9'h03C, then rst=1 for one edge → s=9'bz. Deassert rst with EN=1, w=9'h001 → s=9'h001 next edge.
- Streaming: EN=1, w=0,1,2,…,8 on consecutive cycles → s follows with exactly one cycle lag. No gaps.
